// File: rtl/dpram_pkg.sv
// Shared constants, state type and sizing helper for the byte-enabled dual-port RAM.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int nbytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_lane.sv
// One byte lane of the RAM: storage array, registered read port and the
// read-during-write bypass used in write-first mode.
module dpram_lane
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BYTE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BYTE_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem_q [DEPTH];
  logic [BYTE_WIDTH-1:0] rdata_d;
  logic [BYTE_WIDTH-1:0] rdata_q;
  logic                  bypass;

  always_comb begin
    bypass = (RDW_MODE == RDW_WRITE_FIRST) && we && (waddr == raddr);
    if (!re) begin
      rdata_d = rdata_q;
    end else if (bypass) begin
      rdata_d = wdata;
    end else begin
      rdata_d = mem_q[raddr];
    end
  end

  // The array is deliberately not reset; the top-level clear sequencer handles that.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dpram_be.sv
// Single-clock dual-port RAM with byte enables, selectable read-during-write,
// optional output register and a post-reset clear sequencer.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    RDW_MODE       = 0,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   NBYTES         = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic [NBYTES-1:0]     wrbe,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic                  rdvalid,
  output logic                  busy
);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST    = '1;
  localparam state_e                RESET_STATE =
    state_e'((CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  clearing;
  logic                  rd_req;
  logic [NBYTES-1:0]     lane_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] lane_data;

  always_comb begin
    clearing = (state_q == ST_CLEAR);
    rd_req   = rden && (state_q == ST_READY);
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The clear sequencer owns the write port while busy; user requests are dropped.
  always_comb begin
    if (clearing) begin
      mem_waddr = cnt_q;
      mem_wdata = CLEAR_VALUE;
      lane_we   = {NBYTES{rst_n}};
    end else begin
      mem_waddr = wraddr;
      mem_wdata = wrdata;
      lane_we   = wrbe & {NBYTES{wren && rst_n && (state_q == ST_READY)}};
    end
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    dpram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .RDW_MODE   (RDW_MODE)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[i]),
      .waddr (mem_waddr),
      .wdata (mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH]),
      .re    (rd_req),
      .raddr (rdaddr),
      .rdata (lane_data[i*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  stage_vld_d;
    logic                  stage_vld_q;
    logic                  rdvalid_d;
    logic                  rdvalid_q;
    logic [DATA_WIDTH-1:0] rddata_d;
    logic [DATA_WIDTH-1:0] rddata_q;

    always_comb begin
      stage_vld_d = rd_req;
      rdvalid_d   = stage_vld_q;
      if (stage_vld_q) begin
        rddata_d = lane_data;
      end else begin
        rddata_d = rddata_q;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_vld_q <= 1'b0;
        rdvalid_q   <= 1'b0;
        rddata_q    <= '0;
      end else begin
        stage_vld_q <= stage_vld_d;
        rdvalid_q   <= rdvalid_d;
        rddata_q    <= rddata_d;
      end
    end

    assign rddata  = rddata_q;
    assign rdvalid = rdvalid_q;
  end else begin : g_no_out_reg
    logic rdvalid_d;
    logic rdvalid_q;

    always_comb begin
      rdvalid_d = rd_req;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdvalid_q <= 1'b0;
      end else begin
        rdvalid_q <= rdvalid_d;
      end
    end

    // Lane read registers only load on a read, so they already hold between reads.
    assign rddata  = lane_data;
    assign rdvalid = rdvalid_q;
  end

  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: three variants share one stimulus stream
// (read-first, write-first, output-registered), a fourth runs without clear-on-reset.
module tb_dpram_be;

  logic        clk;
  logic        rst_n;
  logic        wren;
  logic [3:0]  wraddr;
  logic [15:0] wrdata;
  logic [1:0]  wrbe;
  logic        rden;
  logic [3:0]  rdaddr;
  logic [15:0] rd0, rd1, rd2, rd3;
  logic        v0, v1, v2, v3;
  logic        b0, b1, b2, b3;

  logic        rst3_n;
  logic        wren3;
  logic [3:0]  wraddr3;
  logic [15:0] wrdata3;
  logic [1:0]  wrbe3;
  logic        rden3;
  logic [3:0]  rdaddr3;

  int n_cmp = 0;
  int n_bad = 0;

  dpram_be #(.RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
    .rden(rden), .rdaddr(rdaddr), .rddata(rd0), .rdvalid(v0), .busy(b0));
  dpram_be #(.RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
    .rden(rden), .rdaddr(rdaddr), .rddata(rd1), .rdvalid(v1), .busy(b1));
  dpram_be #(.RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
    .rden(rden), .rdaddr(rdaddr), .rddata(rd2), .rdvalid(v2), .busy(b2));
  dpram_be #(.RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(0)) u3 (
    .clk(clk), .rst_n(rst3_n), .wren(wren3), .wraddr(wraddr3), .wrdata(wrdata3), .wrbe(wrbe3),
    .rden(rden3), .rdaddr(rdaddr3), .rddata(rd3), .rdvalid(v3), .busy(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wren = 1'b1; wraddr = a; wrdata = d; wrbe = be;
    tick();
    wren = 1'b0;
  endtask

  // Read one address on the shared port; any write the caller set up rides along for one cycle.
  task automatic rd_all(input string tag, input logic [3:0] a,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    rden = 1'b1; rdaddr = a;
    tick();
    rden = 1'b0; wren = 1'b0;
    check({tag, "/v0"}, 32'(v0), 32'd1);
    check({tag, "/d0"}, 32'(rd0), 32'(e0));
    check({tag, "/v1"}, 32'(v1), 32'd1);
    check({tag, "/d1"}, 32'(rd1), 32'(e1));
    check({tag, "/v2_early"}, 32'(v2), 32'd0);
    tick();
    check({tag, "/v2"}, 32'(v2), 32'd1);
    check({tag, "/d2"}, 32'(rd2), 32'(e2));
    check({tag, "/v0_strobe"}, 32'(v0), 32'd0);
  endtask

  task automatic count_busy(input bit with_req, output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (b0 && n < 40) begin
      if (with_req) begin
        wren = 1'b1; wraddr = 4'd2; wrdata = 16'h5555; wrbe = 2'b11;
        rden = 1'b1; rdaddr = 4'd2;
      end
      n++;
      tick();
      if (v0 || v1 || v2) saw_valid = 1'b1;
    end
    wren = 1'b0;
    rden = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          sv;
    logic [15:0] vals [4];
    vals[0] = 16'h0102; vals[1] = 16'h0304; vals[2] = 16'h0506; vals[3] = 16'h0708;

    rst_n = 1'b0; wren = 1'b0; wraddr = 4'd0; wrdata = 16'h0000; wrbe = 2'b00;
    rden = 1'b0; rdaddr = 4'd0;
    rst3_n = 1'b0; wren3 = 1'b0; wraddr3 = 4'd0; wrdata3 = 16'h0000; wrbe3 = 2'b00;
    rden3 = 1'b0; rdaddr3 = 4'd0;
    repeat (3) tick();

    check("rst/v0", 32'(v0), 32'd0);
    check("rst/d0", 32'(rd0), 32'd0);
    check("rst/busy0", 32'(b0), 32'd1);
    check("rst/v2", 32'(v2), 32'd0);
    check("rst/d2", 32'(rd2), 32'd0);
    check("rst/busy3", 32'(b3), 32'd0);
    check("rst/v3", 32'(v3), 32'd0);

    // Test 1: clear length and back-to-back reads of the cleared array
    rst_n = 1'b1;
    count_busy(1'b0, n, sv);
    check("t1/busy_len", 32'(n), 32'd16);
    check("t1/busy2_done", 32'(b2), 32'd0);
    for (int k = 0; k <= 16; k++) begin
      rden = (k < 16); rdaddr = 4'(k);
      tick();
      if (k < 16) begin
        check("t1/v0", 32'(v0), 32'd1);
        check("t1/d0", 32'(rd0), 32'd0);
      end else begin
        check("t1/v0_end", 32'(v0), 32'd0);
      end
      if (k >= 1) begin
        check("t1/v2", 32'(v2), 32'd1);
        check("t1/d2", 32'(rd2), 32'd0);
      end
    end
    rden = 1'b0;
    tick();
    check("t1/v2_end", 32'(v2), 32'd0);

    // Test 2: byte enables
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd_all("t2/merge", 4'd3, 16'hAB34, 16'hAB34, 16'hAB34);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd_all("t2/be0", 4'd3, 16'hAB34, 16'hAB34, 16'hAB34);

    // Test 3: read-during-write
    wr(4'd5, 16'h1111, 2'b11);
    wren = 1'b1; wraddr = 4'd5; wrdata = 16'h2222; wrbe = 2'b11;
    rd_all("t3/rdw_full", 4'd5, 16'h1111, 16'h2222, 16'h1111);
    wr(4'd5, 16'h1111, 2'b11);
    wren = 1'b1; wraddr = 4'd5; wrdata = 16'h2222; wrbe = 2'b01;
    rd_all("t3/rdw_lane", 4'd5, 16'h1111, 16'h1122, 16'h1111);
    wren = 1'b1; wraddr = 4'd6; wrdata = 16'h7777; wrbe = 2'b11;
    rd_all("t3/other_addr", 4'd5, 16'h1122, 16'h1122, 16'h1122);
    rd_all("t3/addr6", 4'd6, 16'h7777, 16'h7777, 16'h7777);

    // Test 4: output-registered latency, streaming, and hold
    for (int k = 0; k < 4; k++) wr(4'(8 + k), vals[k], 2'b11);
    for (int k = 0; k <= 5; k++) begin
      rden = (k < 4); rdaddr = 4'(8 + k);
      tick();
      if (k == 0) begin
        check("t4/v2_lat", 32'(v2), 32'd0);
      end else if (k <= 4) begin
        check("t4/v2", 32'(v2), 32'd1);
        check("t4/d2", 32'(rd2), 32'(vals[k-1]));
      end else begin
        check("t4/v2_off", 32'(v2), 32'd0);
        check("t4/d2_hold", 32'(rd2), 32'(vals[3]));
      end
    end
    rden = 1'b0;
    tick(); tick();
    check("t4/d2_hold2", 32'(rd2), 32'(vals[3]));
    check("t4/d0_hold", 32'(rd0), 32'(vals[3]));

    // Test 5: reset mid-clear restarts the full sequence; requests during busy are dropped
    for (int k = 0; k < 16; k++) wr(4'(k), 16'hFFFF, 2'b11);
    rd_all("t5/filled", 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(1'b1, n, sv);
    check("t5/busy_len", 32'(n), 32'd16);
    check("t5/no_valid_busy", 32'(sv), 32'd0);
    for (int k = 0; k < 16; k++) rd_all("t5/cleared", 4'(k), 16'h0000, 16'h0000, 16'h0000);

    // Test 6: no clear-on-reset; first-cycle access and in-flight read dropped by reset
    rst3_n = 1'b1;
    check("t6/busy_rel", 32'(b3), 32'd0);
    wren3 = 1'b1; wraddr3 = 4'd15; wrdata3 = 16'hBEEF; wrbe3 = 2'b11;
    tick();
    wren3 = 1'b0;
    check("t6/busy_run", 32'(b3), 32'd0);
    rden3 = 1'b1; rdaddr3 = 4'd15;
    tick();
    rden3 = 1'b0;
    check("t6/v3_lat", 32'(v3), 32'd0);
    tick();
    check("t6/v3", 32'(v3), 32'd1);
    check("t6/d3", 32'(rd3), 32'hBEEF);
    rden3 = 1'b1;
    tick();
    rden3 = 1'b0;
    rst3_n = 1'b0;
    tick();
    check("t6/v3_drop", 32'(v3), 32'd0);
    check("t6/d3_rst", 32'(rd3), 32'd0);
    tick();
    check("t6/v3_drop2", 32'(v3), 32'd0);
    rst3_n = 1'b1;
    tick();
    check("t6/v3_after", 32'(v3), 32'd0);
    check("t6/busy_after", 32'(b3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
